// File: rtl/mult_datapath.sv
// Shift-and-add datapath for the sequential multiplier: holds operands, partial
// product and iteration count, and publishes the A_WIDTH x 64 product.
module mult_datapath #(
    parameter int A_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [A_WIDTH-1:0]     a,
    input  logic [63:0]            b,
    input  logic                   s,
    input  logic                   en1,
    input  logic                   en2,
    output logic                   not64,
    output logic [A_WIDTH+63:0]    product,
    output logic                   done
);
    localparam int P_W = A_WIDTH + 64;
    localparam logic [6:0] CNT_END = 7'd64;

    logic [A_WIDTH-1:0] areg_q, areg_d;
    logic [A_WIDTH-1:0] hi_q, hi_d;
    logic [63:0]        lo_q, lo_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [P_W-1:0]     product_q, product_d;
    logic               done_q, done_d;

    // One multiplier bit per step: the carry out of the add lands in the top
    // bit of hi after the shift, so nothing is lost.
    function automatic logic [P_W-1:0] shift_add(
        input logic [A_WIDTH-1:0] hi_v,
        input logic [63:0]        lo_v,
        input logic [A_WIDTH-1:0] m_v
    );
        logic [A_WIDTH:0] sum;
        logic [P_W:0]     cat;
        sum = {1'b0, hi_v} + (lo_v[0] ? {1'b0, m_v} : {(A_WIDTH+1){1'b0}});
        cat = {sum, lo_v};
        return cat[P_W:1];
    endfunction

    always_comb begin
        areg_d    = areg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = en2 ? {hi_q, lo_q} : product_q;
        done_d    = en2;
        if (en1) begin
            if (!s) begin
                areg_d = a;
                lo_d   = b;
                hi_d   = '0;
                cnt_d  = '0;
            end else if (cnt_q != CNT_END) begin
                // Once cnt reaches 64 the controller's extra iterate cycle must not step again.
                {hi_d, lo_d} = shift_add(hi_q, lo_q, areg_q);
                cnt_d        = cnt_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            areg_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= CNT_END;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            areg_q    <= areg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign not64   = (cnt_q != CNT_END);
    assign product = product_q;
    assign done    = done_q;
endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: a small controller model sequences load,
// iterate, hold and capture; each scenario task checks its own results.
module tb_mult_datapath;
    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         s;
    logic         en1;
    logic         en2;
    logic         not64;
    logic [127:0] product;
    logic         done;

    int tests_run = 0;
    int tests_failed = 0;

    mult_datapath #(.A_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .s(s), .en1(en1), .en2(en2),
        .not64(not64), .product(product), .done(done)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge, outputs are read on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Controller model: load, iterate while not64, one hold cycle, one en2 cycle.
    task automatic drive_run(input logic [63:0] av, input logic [63:0] bv,
                             output int hi_cycles, output logic [127:0] prod,
                             output logic dn, output logic dn_after);
        reset = 0; en2 = 0; en1 = 1; s = 0; a = av; b = bv;
        cycle();
        s = 1;
        hi_cycles = 0;
        while (not64 && hi_cycles < 100) begin
            hi_cycles++;
            cycle();
        end
        cycle();
        en1 = 0; s = 0; en2 = 1;
        cycle();
        prod = product;
        dn = done;
        en2 = 0;
        cycle();
        dn_after = done;
    endtask

    task automatic test_reset();
        reset = 1; en1 = 0; en2 = 0; s = 0; a = '0; b = '0;
        cycle();
        cycle();
        tests_run++;
        if (not64 !== 1'b0) begin tests_failed++; $display("FAIL reset_not64 got %b want 0", not64); end
        tests_run++;
        if (product !== 128'd0) begin tests_failed++; $display("FAIL reset_product got %0h want 0", product); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        reset = 0;
    endtask

    task automatic test_small();
        int n; logic [127:0] p; logic d, da;
        drive_run(64'd3, 64'd5, n, p, d, da);
        tests_run++;
        if (n !== 64) begin tests_failed++; $display("FAIL small_not64_cycles got %0d want 64", n); end
        tests_run++;
        if (p !== 128'd15) begin tests_failed++; $display("FAIL small_product got %0d want 15", p); end
        tests_run++;
        if (d !== 1'b1) begin tests_failed++; $display("FAIL small_done got %b want 1", d); end
        tests_run++;
        if (da !== 1'b0) begin tests_failed++; $display("FAIL small_done_fall got %b want 0", da); end
    endtask

    task automatic test_max();
        int n; logic [127:0] p; logic d, da;
        drive_run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, n, p, d, da);
        tests_run++;
        if (p !== 128'hFFFFFFFFFFFFFFFE_0000000000000001) begin
            tests_failed++; $display("FAIL max_product got %0h want fffffffffffffffe0000000000000001", p);
        end
    endtask

    task automatic test_zero_bit63();
        int n; logic [127:0] p; logic d, da;
        drive_run(64'hDEAD_BEEF, 64'd0, n, p, d, da);
        tests_run++;
        if (p !== 128'd0) begin tests_failed++; $display("FAIL zero_product got %0h want 0", p); end
        drive_run(64'd1, 64'h8000_0000_0000_0000, n, p, d, da);
        tests_run++;
        if (p !== 128'h8000_0000_0000_0000) begin
            tests_failed++; $display("FAIL bit63_product got %0h want 8000000000000000", p);
        end
    endtask

    task automatic test_iterate_hold();
        logic want;
        en2 = 0; en1 = 1; s = 0; a = 64'd7; b = 64'd9;
        cycle();
        s = 1;
        for (int k = 1; k <= 70; k++) begin
            cycle();
            want = (k < 64);
            tests_run++;
            if (not64 !== want) begin
                tests_failed++; $display("FAIL hold_not64 cycle %0d got %b want %b", k, not64, want);
            end
        end
        en1 = 0; s = 0; en2 = 1;
        cycle();
        en2 = 0;
        tests_run++;
        if (product !== 128'd63) begin tests_failed++; $display("FAIL hold_product got %0d want 63", product); end
    endtask

    task automatic test_reset_mid();
        int n; logic [127:0] p; logic d, da;
        en2 = 0; en1 = 1; s = 0; a = 64'd100; b = 64'd200;
        cycle();
        s = 1;
        for (int k = 0; k < 30; k++) cycle();
        reset = 1; en2 = 1;
        cycle();
        reset = 0; en1 = 0; s = 0; en2 = 0;
        tests_run++;
        if (not64 !== 1'b0) begin tests_failed++; $display("FAIL midreset_not64 got %b want 0", not64); end
        tests_run++;
        if (product !== 128'd0) begin tests_failed++; $display("FAIL midreset_product got %0h want 0", product); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL midreset_done got %b want 0", done); end
        drive_run(64'd100, 64'd200, n, p, d, da);
        tests_run++;
        if (p !== 128'd20000) begin tests_failed++; $display("FAIL midreset_rerun got %0d want 20000", p); end
    endtask

    task automatic test_reload();
        int n; logic [127:0] p; logic d, da;
        en2 = 0; en1 = 1; s = 0; a = 64'd5; b = 64'd6;
        cycle();
        s = 1;
        for (int k = 0; k < 10; k++) cycle();
        drive_run(64'd11, 64'd13, n, p, d, da);
        tests_run++;
        if (n !== 64) begin tests_failed++; $display("FAIL reload_cycles got %0d want 64", n); end
        tests_run++;
        if (p !== 128'd143) begin tests_failed++; $display("FAIL reload_product got %0d want 143", p); end
    endtask

    // en2 held for several cycles with the datapath idle: product steady, done high.
    task automatic test_back_to_back();
        int n; logic [127:0] p; logic d, da;
        drive_run(64'd12, 64'd12, n, p, d, da);
        en1 = 0; s = 0; en2 = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests_run++;
            if (product !== 128'd144 || done !== 1'b1) begin
                tests_failed++; $display("FAIL held_en2 cycle %0d got %0d/%b want 144/1", k, product, done);
            end
        end
        en2 = 0;
        cycle();
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL held_en2_fall got %b want 0", done); end
        tests_run++;
        if (product !== 128'd144) begin tests_failed++; $display("FAIL held_en2_keep got %0d want 144", product); end
    endtask

    initial begin
        reset = 1; en1 = 0; en2 = 0; s = 0; a = '0; b = '0;
        @(negedge clk);
        test_reset();
        test_small();
        test_max();
        test_zero_bit63();
        test_iterate_hold();
        test_reset_mid();
        test_reload();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
